// File: rtl/testbench_ls_irq_ctrl.sv
// ============================================================================
// Module   : testbench_ls_irq_ctrl
// Purpose  : Avalon-MM slave interrupt controller. Latches NUM_IRQ request
//            lines into a pending register, masks them, drives a single CPU
//            irq plus the index of the highest-priority active source (bit 0
//            highest), and counts requests lost while a bit was already set.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_IRQ  number of request sources, 1..16 (bit 0 = timer, top priority)
//   ID_W     width of irq_id, 2**ID_W >= NUM_IRQ, at most 15
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   [2:0]  register word address
//   chipselect in   slave select
//   write_n    in   active-low write strobe (qualified by chipselect)
//   writedata  in   [15:0] write data
//   readdata   out  [15:0] registered read data, latency 1
//   irq_in     in   [NUM_IRQ-1:0] level request lines, same clock domain
//   irq        out  registered CPU interrupt
//   irq_id     out  [ID_W-1:0] registered index of lowest active bit
// Register map
//   0 PENDING R/W1C, 1 MASK RW, 2 ACTIVE RO, 3 VECTOR RO,
//   4 EDGE_SEL RW (optional), 5 FORCE WO, 6 LOST R/Wclr, 7 reserved
// Configuration macro
//   IRQ_CTRL_EDGE_SEL_EN : adds the per-source EDGE_SEL register at address 4
//                          (1 = edge mode, 0 = level mode). Undefined: every
//                          source is edge mode and address 4 reads 0.
// ============================================================================
`default_nettype none

module testbench_ls_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);

  localparam logic [2:0] c_ADDR_PENDING  = 3'd0;
  localparam logic [2:0] c_ADDR_MASK     = 3'd1;
  localparam logic [2:0] c_ADDR_ACTIVE   = 3'd2;
  localparam logic [2:0] c_ADDR_VECTOR   = 3'd3;
  localparam logic [2:0] c_ADDR_EDGE_SEL = 3'd4;
  localparam logic [2:0] c_ADDR_FORCE    = 3'd5;
  localparam logic [2:0] c_ADDR_LOST     = 3'd6;
  localparam logic [15:0] c_LOST_MAX     = 16'hFFFF;

  logic [NUM_IRQ-1:0] r_irq_q;
  logic               r_rise_en;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [15:0]        r_lost;
  logic [15:0]        r_readdata;
  logic               r_irq;
  logic [ID_W-1:0]    r_irq_id;

  logic               w_wr;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_force;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_edge_mode;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic               w_lost_evt;
  logic [NUM_IRQ-1:0] w_act;
  logic [ID_W-1:0]    w_irq_id_nxt;
  logic [15:0]        w_rdata;
  logic               w_unused_wdata;

  // Upper writedata bits are deliberately ignored when NUM_IRQ < 16.
  assign w_unused_wdata = ^writedata;

  assign w_wr    = chipselect & ~write_n;
  assign w_w1c   = (w_wr && address == c_ADDR_PENDING) ? writedata[NUM_IRQ-1:0] : '0;
  assign w_force = (w_wr && address == c_ADDR_FORCE)   ? writedata[NUM_IRQ-1:0] : '0;

  // r_rise_en stays low for the first cycle after reset release so that a
  // source already high when reset drops is seen as a level, not an edge:
  // r_irq_q catches up during that cycle.
  assign w_rise = irq_in & ~r_irq_q & {NUM_IRQ{r_rise_en}};

`ifdef IRQ_CTRL_EDGE_SEL_EN
  logic [NUM_IRQ-1:0] r_edge_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_sel <= '1;
    end else if (w_wr && address == c_ADDR_EDGE_SEL) begin
      r_edge_sel <= writedata[NUM_IRQ-1:0];
    end
  end

  assign w_edge_mode = r_edge_sel;
`else
  assign w_edge_mode = '1;
`endif

  // Edge bits: set (rise/force) wins over a same-cycle W1C.
  // Level bits simply follow the request line.
  assign w_pending_nxt = (w_edge_mode & ((r_pending & ~w_w1c) | w_rise | w_force))
                       | (~w_edge_mode & irq_in);

  // A rise on an edge bit that is already pending is a lost request.
  assign w_lost_evt = |(w_edge_mode & w_rise & r_pending);

  assign w_act = r_pending & r_mask;

  // Lowest set bit wins: scan downward so the last hit is the lowest index.
  always_comb begin
    w_irq_id_nxt = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_irq_id_nxt = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      c_ADDR_PENDING: w_rdata[NUM_IRQ-1:0] = r_pending;
      c_ADDR_MASK:    w_rdata[NUM_IRQ-1:0] = r_mask;
      c_ADDR_ACTIVE:  w_rdata[NUM_IRQ-1:0] = w_act;
      c_ADDR_VECTOR: begin
        w_rdata[ID_W-1:0] = r_irq_id;
        w_rdata[15]       = r_irq;
      end
`ifdef IRQ_CTRL_EDGE_SEL_EN
      c_ADDR_EDGE_SEL: w_rdata[NUM_IRQ-1:0] = r_edge_sel;
`endif
      c_ADDR_LOST:    w_rdata = r_lost;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_q    <= '0;
      r_rise_en  <= 1'b0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_lost     <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
      r_irq_id   <= '0;
    end else begin
      r_irq_q    <= irq_in;
      r_rise_en  <= 1'b1;
      r_pending  <= w_pending_nxt;
      r_readdata <= w_rdata;
      r_irq      <= |w_act;
      r_irq_id   <= w_irq_id_nxt;

      if (w_wr && address == c_ADDR_MASK) begin
        r_mask <= writedata[NUM_IRQ-1:0];
      end

      // A clear coinciding with a lost event leaves a count of one.
      if (w_wr && address == c_ADDR_LOST) begin
        r_lost <= {15'd0, w_lost_evt};
      end else if (w_lost_evt && r_lost != c_LOST_MAX) begin
        r_lost <= r_lost + 16'd1;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;
  assign irq_id   = r_irq_id;

endmodule

`default_nettype wire

// File: tb/tb_testbench_ls_irq_ctrl.sv
// ============================================================================
// Module   : tb_testbench_ls_irq_ctrl
// Purpose  : Self-checking bench for testbench_ls_irq_ctrl (NUM_IRQ=8, ID_W=4)
//            with a cycle-level behavioural model, directed scenarios and a
//            randomized phase. Honours IRQ_CTRL_EDGE_SEL_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_testbench_ls_irq_ctrl;

  localparam int N   = 8;
  localparam int IDW = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [2:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [15:0]   writedata  = '0;
  logic [15:0]   readdata;
  logic [N-1:0]  irq_in     = '0;
  logic          irq;
  logic [IDW-1:0] irq_id;

  int checks = 0;
  int errors = 0;
  logic [15:0] d;

  always #5 clk = ~clk;

  testbench_ls_irq_ctrl #(.NUM_IRQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq),
    .irq_id     (irq_id)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]   m_pend, m_mask, m_prev_in, m_edge;
  logic [15:0]    m_lost, m_rd;
  logic           m_armed, m_irq;
  logic [IDW-1:0] m_id;

  always @(posedge clk or negedge reset_n) begin : model
    logic [N-1:0] np, act;
    logic [15:0]  rd;
    logic         wr, ev, rise, found;
    int           id;
    if (!reset_n) begin
      m_pend <= '0; m_mask <= '0; m_prev_in <= '0; m_edge <= '1;
      m_lost <= '0; m_rd <= '0; m_armed <= 1'b0; m_irq <= 1'b0; m_id <= '0;
    end else begin
      wr = chipselect && !write_n;
      ev = 1'b0;
      for (int i = 0; i < N; i++) begin
        rise = irq_in[i] && !m_prev_in[i] && m_armed;
        if (m_edge[i]) begin
          np[i] = (m_pend[i] && !(wr && address == 3'd0 && writedata[i]))
                  || rise || (wr && address == 3'd5 && writedata[i]);
          if (rise && m_pend[i]) ev = 1'b1;
        end else begin
          np[i] = irq_in[i];
        end
      end
      act   = m_pend & m_mask;
      id    = 0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (act[i] && !found) begin
          id = i;
          found = 1'b1;
        end
      end
      case (address)
        3'd0:    rd = {8'h00, m_pend};
        3'd1:    rd = {8'h00, m_mask};
        3'd2:    rd = {8'h00, act};
        3'd3:    rd = {m_irq, 11'b0, m_id};
`ifdef IRQ_CTRL_EDGE_SEL_EN
        3'd4:    rd = {8'h00, m_edge};
`endif
        3'd6:    rd = m_lost;
        default: rd = 16'h0000;
      endcase
      m_pend    <= np;
      m_prev_in <= irq_in;
      m_armed   <= 1'b1;
      m_irq     <= (act != '0);
      m_id      <= IDW'(id);
      m_rd      <= rd;
      if (wr && address == 3'd1) m_mask <= writedata[N-1:0];
`ifdef IRQ_CTRL_EDGE_SEL_EN
      if (wr && address == 3'd4) m_edge <= writedata[N-1:0];
`endif
      if (wr && address == 3'd6)            m_lost <= ev ? 16'd1 : 16'd0;
      else if (ev && m_lost != 16'hFFFF)    m_lost <= m_lost + 16'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("irq", int'(irq), int'(m_irq));
    check("irq_id", int'(irq_id), int'(m_id));
    check("readdata", int'(readdata), int'(m_rd));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    v = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Reset state
    check("rst_irq", int'(irq), 0);
    check("rst_irq_id", int'(irq_id), 0);
    check("rst_readdata", int'(readdata), 0);
    bus_rd(3'd1, d); check("rst_mask", int'(d), 0);

    // 1: single timer source, latency and VECTOR
    bus_wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    tick();
    check("t1_irq_n+1", int'(irq), 0);
    bus_rd(3'd0, d);
    check("t1_pending", int'(d), 16'h0001);
    check("t1_irq_n+2", int'(irq), 1);
    check("t1_irq_id", int'(irq_id), 0);
    bus_rd(3'd3, d);
    check("t1_vector", int'(d), 16'h8000);

    // 2: priority between two simultaneous sources
    irq_in[0] = 1'b0;
    bus_wr(3'd0, 16'h0001);
    bus_wr(3'd1, 16'h00FF);
    irq_in[3] = 1'b1; irq_in[5] = 1'b1;
    tick(2);
    check("t2_irq_id3", int'(irq_id), 3);
    bus_wr(3'd0, 16'h0008);
    tick();
    check("t2_irq_id5", int'(irq_id), 5);
    bus_wr(3'd0, 16'h0020);
    tick();
    check("t2_irq_off", int'(irq), 0);

    // 3: lost counter, clear, saturation
    irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0; tick();
    irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0; tick();
    bus_rd(3'd0, d); check("t3_pending", int'(d), 16'h0004);
    bus_rd(3'd6, d); check("t3_lost1", int'(d), 1);
    bus_wr(3'd6, 16'h1234);
    bus_rd(3'd6, d); check("t3_lost_clr", int'(d), 0);
    // Alternate bits 0 and 1 so one already-pending rise occurs every cycle.
    for (int k = 0; k < 65540; k++) begin
      irq_in[1:0] = k[0] ? 2'b01 : 2'b10;
      tick();
    end
    bus_rd(3'd6, d); check("t3_lost_sat", int'(d), 16'hFFFF);

    // 4: set beats same-cycle W1C; software force
    irq_in[1] = 1'b0; tick();
    irq_in[1] = 1'b1;
    bus_wr(3'd0, 16'h0002);
    bus_rd(3'd0, d); check("t4_set_wins", int'(d[1]), 1);
    bus_wr(3'd1, 16'h0080);
    bus_wr(3'd5, 16'h0080);
    tick();
    check("t4_force_irq", int'(irq), 1);
    check("t4_force_id", int'(irq_id), 7);
    bus_rd(3'd5, d); check("t4_force_rd0", int'(d), 0);

    // 5: EDGE_SEL
`ifdef IRQ_CTRL_EDGE_SEL_EN
    bus_wr(3'd4, 16'hFFFE);
    irq_in[0] = 1'b1;
    tick();
    bus_rd(3'd0, d); check("t5_level_hi", int'(d[0]), 1);
    bus_wr(3'd0, 16'h0001);
    bus_rd(3'd0, d); check("t5_level_w1c", int'(d[0]), 1);
    irq_in[0] = 1'b0;
    tick();
    bus_rd(3'd0, d); check("t5_level_lo", int'(d[0]), 0);
    bus_wr(3'd4, 16'hFFFF);
`else
    bus_wr(3'd4, 16'hFFFF);
    bus_rd(3'd4, d); check("t5_no_edge_sel", int'(d), 0);
`endif

    // 6: reset mid-operation with irq=1 and LOST=5
    bus_wr(3'd6, 16'h0000);
    bus_wr(3'd5, 16'h0004);
    for (int j = 0; j < 5; j++) begin
      irq_in[2] = 1'b1; tick();
      irq_in[2] = 1'b0; tick();
    end
    bus_rd(3'd6, d); check("t6_lost5", int'(d), 5);
    check("t6_irq_before", int'(irq), 1);
    irq_in[2] = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_irq", int'(irq), 0);
    check("t6_rst_id", int'(irq_id), 0);
    check("t6_rst_rd", int'(readdata), 0);
    tick(2);
    #0 reset_n = 1'b1;
    tick(2);
    bus_rd(3'd0, d); check("t6_pending", int'(d), 0);
    bus_rd(3'd1, d); check("t6_mask", int'(d), 0);
    bus_rd(3'd6, d); check("t6_lost", int'(d), 0);
    check("t6_irq_after", int'(irq), 0);

    // Randomized phase
    for (int k = 0; k < 3000; k++) begin
      irq_in     = irq_in ^ N'($urandom & $urandom);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = 16'($urandom);
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
